datapath_sequencer: RTL and testbench
=====================================

DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

Interface
REQ-001 clock  in  1  single clock; all state changes on rising edge.
REQ-002 reset  in  1  asynchronous, active-high; forces reset state immediately.
REQ-003 instr  in  32  command word: op[31:27], da[26:22], sa[21:17], sb[16:12], imm[11:0].
REQ-004 instr_valid  in  1 / instr_ready  out  1  accept handshake; transfer when both high at rising edge.
REQ-005 status  in  4  datapath flags {V,C,N,Z}, sampled only when COND_EXEC_EN is defined.
REQ-006 DA, SA, SB  out  5 each  register-file dest/source selects.
REQ-007 W  out  1  register-file write enable; K  out  64  constant; BS  out  1  1 selects K as ALU B input.
REQ-008 FS  out  5  ALU function select; write  out  1  memory write; selEN  out  1  1 = ALU result drives data bus, 0 = memory read data.
REQ-009 done  out  1  one-cycle pulse on an instruction's final cycle; illegal  out  1  one-cycle pulse for an undefined op.

Function
REQ-010 States: IDLE, EXEC, MEM_RD, WB; instr_ready SHALL be high only in IDLE.
REQ-011 IDLE->EXEC on handshake; the command SHALL be registered, and a new instr_valid outside IDLE SHALL be ignored.
REQ-012 Ops: NOP=0, ADD=1, ADDI=2, ORI=3, XOR=4, LSL=5, STUR=6, LDUR=7; codes 8-31 SHALL be treated as NOP with illegal pulsed in EXEC.
REQ-013 K SHALL equal imm zero-extended to 64 bits; BS=1 for ADDI/ORI/LSL/STUR/LDUR, 0 otherwise.
REQ-014 FS: ADD/ADDI/STUR/LDUR=01000, ORI=00100, XOR=01100, LSL=10000, NOP=00000.
REQ-015 ADD/ADDI/ORI/XOR/LSL: in EXEC, W=1, selEN=1, write=0; done=1; next state IDLE.
REQ-016 STUR: in EXEC, SA=base, SB=data reg, write=1, W=0, selEN=0; done=1; next IDLE.
REQ-017 LDUR: EXEC drives the address (W=0, write=0, selEN=0) -> MEM_RD; MEM_RD holds the address -> WB; WB drives W=1, selEN=0, DA=dest, done=1 -> IDLE.
REQ-018 NOP/illegal: EXEC with W=0, write=0; done=1; next IDLE.
REQ-019 In IDLE: W=0, write=0, done=0, illegal=0; the selects keep their last values.
REQ-020 W and write SHALL never be high in the same cycle.
REQ-021 Latency: a command accepted at edge N executes in cycle N+1 (N+1..N+3 for LDUR); peak throughput is one command per 2 cycles.

Reset
REQ-022 On reset: state=IDLE, instr_ready=1, W=0, write=0, done=0, illegal=0, selEN=1, BS=0, FS=0, K=0, DA=SA=SB=0.
REQ-023 Reset asserted mid-instruction, including MEM_RD or WB, SHALL abort it with no further W/write pulse and no done.
REQ-024 The first handshake is accepted at the first rising edge after reset deasserts.

Configuration
REQ-025 Macro DATAPATH_SEQUENCER_COND_EXEC_EN: when defined, instr[11] of ADD/XOR is a "skip if Z" bit; if set and status[0]=1 in EXEC, W SHALL be forced to 0 while done still pulses.
REQ-026 Without the macro, status is unused and instr[11] is ordinary immediate/ignored data.

Structure
REQ-027 Package datapath_ctrl_pkg SHALL hold the opcode constants, FS constants, field bit positions and state encoding.
REQ-028 Sub-module cw_decode (combinational: opcode -> BS, FS, W, write, selEN, is_load, illegal) SHALL be instantiated once; the FSM stays in datapath_sequencer.

Verification
REQ-029 Reset high mid-LDUR (in MEM_RD) -> next cycle W=0, write=0, instr_ready=1, done never pulses.
REQ-030 ADDI da=5 sa=31 imm=24 -> cycle after accept: DA=5, SA=31, K=24, BS=1, FS=01000, W=1, selEN=1, done=1.
REQ-031 ADD da=1 sa=5 sb=7, then XOR da=30 sa=1 sb=5, back-to-back valid -> second accepted 2 cycles after first; FS 01000 then 01100, BS=0.
REQ-032 STUR sa=7 sb=17 -> write=1, W=0, selEN=0 for exactly 1 cycle; LDUR da=0 sa=7 -> W=0 for 2 cycles, then W=1, selEN=0, DA=0, done=1.
REQ-033 op=5'd20 -> illegal=1 and done=1 in the same cycle, W=0, write=0.
REQ-034 With the macro defined: ADD with instr[11]=1 and status=4'b0001 -> W=0, done=1; same with status=4'b0000 -> W=1.

Source files
------------

// File: rtl/datapath_ctrl_pkg.sv
// Shared constants for the datapath sequencer: opcodes, ALU function selects,
// command-word field positions and FSM state encoding.
package datapath_ctrl_pkg;

    localparam int FIELD_W  = 5;
    localparam int IMM_W    = 12;
    localparam int OP_LSB   = 27;
    localparam int DA_LSB   = 22;
    localparam int SA_LSB   = 17;
    localparam int SB_LSB   = 12;
    localparam int IMM_LSB  = 0;
    localparam int SKIP_BIT = 11;

    localparam logic [4:0] OP_NOP  = 5'd0;
    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_ADDI = 5'd2;
    localparam logic [4:0] OP_ORI  = 5'd3;
    localparam logic [4:0] OP_XOR  = 5'd4;
    localparam logic [4:0] OP_LSL  = 5'd5;
    localparam logic [4:0] OP_STUR = 5'd6;
    localparam logic [4:0] OP_LDUR = 5'd7;

    localparam logic [4:0] FS_NONE = 5'b00000;
    localparam logic [4:0] FS_ADD  = 5'b01000;
    localparam logic [4:0] FS_OR   = 5'b00100;
    localparam logic [4:0] FS_XOR  = 5'b01100;
    localparam logic [4:0] FS_LSL  = 5'b10000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_MEM_RD = 2'd2,
        ST_WB     = 2'd3
    } state_e;

    function automatic logic [FIELD_W-1:0] field5(input logic [31:0] instr, input int lsb);
        return instr[lsb +: FIELD_W];
    endfunction

endpackage

// File: rtl/datapath_sequencer_if.sv
// Command handshake plus datapath control-word bundle between a command
// source (master) and the datapath sequencer (slave).
interface datapath_sequencer_if;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  status;
    logic [4:0]  DA;
    logic [4:0]  SA;
    logic [4:0]  SB;
    logic        W;
    logic [63:0] K;
    logic        BS;
    logic [4:0]  FS;
    logic        write;
    logic        selEN;
    logic        done;
    logic        illegal;

    modport master (
        output instr, instr_valid, status,
        input  instr_ready, DA, SA, SB, W, K, BS, FS, write, selEN, done, illegal
    );

    modport slave (
        input  instr, instr_valid, status,
        output instr_ready, DA, SA, SB, W, K, BS, FS, write, selEN, done, illegal
    );
endinterface

// File: rtl/cw_decode.sv
// Combinational opcode decoder producing the static part of the control word.
// W here means "this op writes the register file"; the FSM decides when.
module cw_decode
    import datapath_ctrl_pkg::*;
(
    input  logic [4:0] i_op,
    output logic       o_bs,
    output logic [4:0] o_fs,
    output logic       o_w,
    output logic       o_write,
    output logic       o_sel_en,
    output logic       o_is_load,
    output logic       o_illegal
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        o_bs      = 1'b0;
        o_fs      = FS_NONE;
        o_w       = 1'b0;
        o_write   = 1'b0;
        o_sel_en  = 1'b1;
        o_is_load = 1'b0;
        o_illegal = 1'b0;
        case (i_op)
            OP_NOP:  ;
            OP_ADD:  begin o_fs = FS_ADD; o_w = 1'b1; end
            OP_ADDI: begin o_fs = FS_ADD; o_w = 1'b1; o_bs = 1'b1; end
            OP_ORI:  begin o_fs = FS_OR;  o_w = 1'b1; o_bs = 1'b1; end
            OP_XOR:  begin o_fs = FS_XOR; o_w = 1'b1; end
            OP_LSL:  begin o_fs = FS_LSL; o_w = 1'b1; o_bs = 1'b1; end
            OP_STUR: begin
                o_fs = FS_ADD; o_bs = 1'b1; o_write = 1'b1; o_sel_en = 1'b0;
            end
            OP_LDUR: begin
                o_fs = FS_ADD; o_bs = 1'b1; o_w = 1'b1; o_sel_en = 1'b0; o_is_load = 1'b1;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/datapath_sequencer.sv
// Command sequencer: accepts one command word in IDLE and steps it through
// EXEC (and MEM_RD/WB for loads). Optional feature macro: DATAPATH_SEQUENCER_COND_EXEC_EN.
module datapath_sequencer
    import datapath_ctrl_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    datapath_sequencer_if.slave  bus
);

    state_e      r_state;
    state_e      w_next_state;
    logic [31:0] r_instr;
    logic [4:0]  w_op;
    logic        w_accept;
    logic        w_skip;
    logic        w_bs, w_w, w_write, w_sel_en, w_is_load, w_illegal;
    logic [4:0]  w_fs;

    assign w_accept = (r_state == ST_IDLE) && bus.instr_valid;
    assign w_op     = field5(r_instr, OP_LSB);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_instr <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values, matching real flops.
            r_state <= w_next_state;
            if (w_accept) r_instr <= bus.instr;
        end
    end

    cw_decode u_cw_decode (
        .i_op      (w_op),
        .o_bs      (w_bs),
        .o_fs      (w_fs),
        .o_w       (w_w),
        .o_write   (w_write),
        .o_sel_en  (w_sel_en),
        .o_is_load (w_is_load),
        .o_illegal (w_illegal)
    );

`ifdef DATAPATH_SEQUENCER_COND_EXEC_EN
    logic w_unused_flags;
    assign w_unused_flags = ^bus.status[3:1];
    assign w_skip = ((w_op == OP_ADD) || (w_op == OP_XOR)) && r_instr[SKIP_BIT] && bus.status[0];
`else
    logic w_unused_status;
    assign w_unused_status = ^{bus.status, r_instr[SKIP_BIT]};
    assign w_skip = 1'b0;
`endif

    // Selects follow the registered command, so they hold their last values in IDLE.
    assign bus.DA          = field5(r_instr, DA_LSB);
    assign bus.SA          = field5(r_instr, SA_LSB);
    assign bus.SB          = field5(r_instr, SB_LSB);
    assign bus.K           = {{(64-IMM_W){1'b0}}, r_instr[IMM_LSB +: IMM_W]};
    assign bus.BS          = w_bs;
    assign bus.FS          = w_fs;
    assign bus.selEN       = w_sel_en;
    assign bus.instr_ready = (r_state == ST_IDLE);

    always_comb begin
        w_next_state = r_state;
        bus.W        = 1'b0;
        bus.write    = 1'b0;
        bus.done     = 1'b0;
        bus.illegal  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.instr_valid) w_next_state = ST_EXEC;
            end
            ST_EXEC: begin
                bus.write   = w_write;
                bus.illegal = w_illegal;
                if (w_is_load) begin
                    w_next_state = ST_MEM_RD;
                end else begin
                    bus.W        = w_w & ~w_skip;
                    bus.done     = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            ST_MEM_RD: w_next_state = ST_WB;
            ST_WB: begin
                bus.W        = 1'b1;
                bus.done     = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer: table-driven single commands,
// a scoreboard checked on every done pulse, and hand-written multi-cycle cases.
module tb_datapath_sequencer;
    import datapath_ctrl_pkg::*;

`ifdef DATAPATH_SEQUENCER_COND_EXEC_EN
    localparam bit COND = 1'b1;
`else
    localparam bit COND = 1'b0;
`endif

    typedef struct {
        logic [31:0] instr;
        logic        w, wr, sel, chk_sel, bs;
        logic [4:0]  fs;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [3:0] status;
        exp_t       exp;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb_q[$];
    vec_t tbl[14];

    always #5 clock = ~clock;

    datapath_sequencer_if bus ();

    datapath_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] da,
                                       input logic [4:0] sa, input logic [4:0] sb,
                                       input logic [11:0] imm);
        return {op, da, sa, sb, imm};
    endfunction

    function automatic exp_t ex(input logic [31:0] instr, input logic w, input logic wr,
                                input logic sel, input logic chk_sel, input logic bs,
                                input logic [4:0] fs, input logic ill);
        exp_t e;
        e.instr = instr; e.w = w; e.wr = wr; e.sel = sel; e.chk_sel = chk_sel;
        e.bs = bs; e.fs = fs; e.ill = ill;
        return e;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && bus.W && bus.write) check("w_write_exclusive", 1, 0);
        if (!reset && bus.done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("DA", bus.DA, e.instr[26:22]);
                check("SA", bus.SA, e.instr[21:17]);
                check("SB", bus.SB, e.instr[16:12]);
                check("K", bus.K, {52'd0, e.instr[11:0]});
                check("W", bus.W, e.w);
                check("write", bus.write, e.wr);
                check("BS", bus.BS, e.bs);
                check("FS", bus.FS, e.fs);
                check("illegal", bus.illegal, e.ill);
                if (e.chk_sel) check("selEN", bus.selEN, e.sel);
            end
        end
    end

    task automatic send(input logic [31:0] instr, input logic [3:0] st, input exp_t e, input bit push);
        int n = 0;
        @(negedge clock);
        while (!bus.instr_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("ready_before_send", bus.instr_ready, 1);
        bus.instr       = instr;
        bus.status      = st;
        bus.instr_valid = 1'b1;
        @(posedge clock);
        #1 bus.instr_valid = 1'b0;
        if (push) sb_q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 10) begin
            @(posedge clock);
            n++;
        end
        check("drain", sb_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] i_add, i_xor, i_ldur, i_addi;
        int n;

        tbl[0]  = '{4'h0, ex(mk(OP_ORI, 5'd3, 5'd4, 5'd0, 12'hFFF), 1, 0, 1, 1, 1, 5'b00100, 0)};
        tbl[1]  = '{4'h0, ex(mk(OP_LSL, 5'd2, 5'd2, 5'd0, 12'd63),  1, 0, 1, 1, 1, 5'b10000, 0)};
        tbl[2]  = '{4'h0, ex(mk(OP_ADD, 5'd9, 5'd10, 5'd11, 12'd0), 1, 0, 1, 1, 0, 5'b01000, 0)};
        tbl[3]  = '{4'h0, ex(mk(OP_XOR, 5'd12, 5'd13, 5'd14, 12'd0), 1, 0, 1, 1, 0, 5'b01100, 0)};
        tbl[4]  = '{4'h0, ex(mk(OP_STUR, 5'd0, 5'd7, 5'd17, 12'd8), 0, 1, 0, 1, 1, 5'b01000, 0)};
        tbl[5]  = '{4'h0, ex(mk(OP_LDUR, 5'd0, 5'd7, 5'd0, 12'd16), 1, 0, 0, 1, 1, 5'b01000, 0)};
        tbl[6]  = '{4'h0, ex(mk(OP_NOP, 5'd6, 5'd8, 5'd9, 12'h123), 0, 0, 0, 0, 0, 5'b00000, 0)};
        tbl[7]  = '{4'h0, ex(mk(5'd20, 5'd1, 5'd2, 5'd3, 12'd5),    0, 0, 0, 0, 0, 5'b00000, 1)};
        tbl[8]  = '{4'h0, ex(mk(5'd31, 5'd4, 5'd5, 5'd6, 12'd7),    0, 0, 0, 0, 0, 5'b00000, 1)};
        tbl[9]  = '{4'h0, ex(mk(5'd8, 5'd31, 5'd31, 5'd31, 12'hABC), 0, 0, 0, 0, 0, 5'b00000, 1)};
        tbl[10] = '{4'h1, ex(mk(OP_ADD, 5'd1, 5'd2, 5'd3, 12'h800), !COND, 0, 1, 1, 0, 5'b01000, 0)};
        tbl[11] = '{4'h0, ex(mk(OP_ADD, 5'd1, 5'd2, 5'd3, 12'h800), 1, 0, 1, 1, 0, 5'b01000, 0)};
        tbl[12] = '{4'h1, ex(mk(OP_XOR, 5'd4, 5'd5, 5'd6, 12'h800), !COND, 0, 1, 1, 0, 5'b01100, 0)};
        tbl[13] = '{4'h1, ex(mk(OP_ADDI, 5'd7, 5'd8, 5'd0, 12'h800), 1, 0, 1, 1, 1, 5'b01000, 0)};

        reset = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        bus.status = '0;
        repeat (2) @(negedge clock);
        check("rst_ready", bus.instr_ready, 1);
        check("rst_W", bus.W, 0);
        check("rst_write", bus.write, 0);
        check("rst_done", bus.done, 0);
        check("rst_illegal", bus.illegal, 0);
        check("rst_selEN", bus.selEN, 1);
        check("rst_BS", bus.BS, 0);
        check("rst_FS", bus.FS, 0);
        check("rst_K", bus.K, 0);
        check("rst_sel_regs", {bus.DA, bus.SA, bus.SB}, 0);
        reset = 1'b0;

        // ADDI da=5 sa=31 imm=24, then selects must hold in IDLE.
        i_addi = mk(OP_ADDI, 5'd5, 5'd31, 5'd0, 12'd24);
        send(i_addi, 4'h0, ex(i_addi, 1, 0, 1, 1, 1, 5'b01000, 0), 1);
        drain();
        @(negedge clock);
        check("idle_hold_DA", bus.DA, 5);
        check("idle_hold_K", bus.K, 24);
        check("idle_W", bus.W, 0);
        check("idle_done", bus.done, 0);

        for (int i = 0; i < 14; i++) begin
            send(tbl[i].exp.instr, tbl[i].status, tbl[i].exp, 1);
            drain();
        end
        bus.status = '0;

        // Back-to-back ADD then XOR with valid held high.
        i_add = mk(OP_ADD, 5'd1, 5'd5, 5'd7, 12'd0);
        i_xor = mk(OP_XOR, 5'd30, 5'd1, 5'd5, 12'd0);
        @(negedge clock);
        bus.instr = i_add;
        bus.instr_valid = 1'b1;
        sb_q.push_back(ex(i_add, 1, 0, 1, 1, 0, 5'b01000, 0));
        @(posedge clock);
        #1 bus.instr = i_xor;
        @(negedge clock);
        check("busy_not_ready", bus.instr_ready, 0);
        n = 0;
        while (!bus.instr_ready && n < 10) begin
            @(negedge clock);
            n++;
        end
        sb_q.push_back(ex(i_xor, 1, 0, 1, 1, 0, 5'b01100, 0));
        @(posedge clock);
        #1 bus.instr_valid = 1'b0;
        check("b2b_accept_gap", n + 1, 2);
        drain();

        // STUR: write high exactly one cycle.
        send(mk(OP_STUR, 5'd0, 5'd7, 5'd17, 12'd0), 4'h0,
             ex(mk(OP_STUR, 5'd0, 5'd7, 5'd17, 12'd0), 0, 1, 0, 1, 1, 5'b01000, 0), 1);
        @(negedge clock);
        @(negedge clock);
        check("stur_write_once", bus.write, 0);

        // LDUR: two cycles with W low, then write-back.
        i_ldur = mk(OP_LDUR, 5'd0, 5'd7, 5'd0, 12'd0);
        send(i_ldur, 4'h0, ex(i_ldur, 1, 0, 0, 1, 1, 5'b01000, 0), 1);
        @(negedge clock);
        check("ldur_exec_W", {bus.W, bus.write, bus.done, bus.selEN}, 0);
        @(negedge clock);
        check("ldur_memrd_W", {bus.W, bus.write, bus.done}, 0);
        check("ldur_memrd_SA", bus.SA, 7);
        drain();

        // Reset in MEM_RD aborts the load; first edge after release accepts.
        send(i_ldur, 4'h0, ex(i_ldur, 1, 0, 0, 1, 1, 5'b01000, 0), 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("abort_now", {bus.W, bus.write, bus.done, bus.instr_ready}, 4'b0001);
        @(negedge clock);
        check("abort_next", {bus.W, bus.write, bus.done, bus.instr_ready}, 4'b0001);
        reset = 1'b0;
        bus.instr = i_addi;
        bus.instr_valid = 1'b1;
        sb_q.push_back(ex(i_addi, 1, 0, 1, 1, 1, 5'b01000, 0));
        @(posedge clock);
        #1 bus.instr_valid = 1'b0;
        @(negedge clock);
        check("first_accept_after_reset", bus.done, 1);
        drain();
        repeat (3) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
